// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP-1 controller-sequencer and the datapath
// blocks around it: opcode values, the one-hot T-state encoding and the
// control-word layout driven onto the register/bus enables.
// ---------------------------------------------------------------------------
package sap_pkg;

    localparam int OP_W  = 4;
    localparam int NUM_T = 6;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    // One-hot ring positions, bit0 = T1.
    typedef enum logic [NUM_T-1:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // Control word, MSB first. mem_enable is active-low towards the bus:
    // 1 keeps the RAM output tri-stated.
    typedef struct packed {
        logic pc_inc;
        logic pc_en;
        logic mar_load;
        logic mem_enable;
        logic ir_load;
        logic ir_en;
        logic a_load;
        logic a_en;
        logic b_load;
        logic out_load;
        logic alu_sub;
        logic alu_en;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = 12'h100;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// ---------------------------------------------------------------------------
// sap_ring_counter
// One-hot T1..T6 ring. Rotates one position per rising edge while advance
// is high, otherwise holds. Asynchronous reset returns the ring to T1.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   advance  in   rotate on this edge
//   t_state  out  one-hot ring position, bit0 = T1
// ---------------------------------------------------------------------------
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [NUM_T-1:0] t_state
);

    t_state_e state;
    t_state_e next_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= T1;
        else     state <= next_state;
    end

    // Any non one-hot value falls back to T1 so the ring self-recovers.
    always_comb begin
        next_state = state;
        if (advance) begin
            case (state)
                T1:      next_state = T2;
                T2:      next_state = T3;
                T3:      next_state = T4;
                T4:      next_state = T5;
                T5:      next_state = T6;
                default: next_state = T1;
            endcase
        end
    end

    assign t_state = state;

endmodule

// File: rtl/sap_controller.sv
// ---------------------------------------------------------------------------
// sap_controller
// SAP-1 controller-sequencer. Steps the T-state ring (fetch T1-T3, execute
// T4-T6), decodes the IR opcode into the control word and holds the sticky
// halt flag. Supports free-run and single-step operation.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run, step         free-run enable / single-step pulse (used when run=0)
//   ir_opcode         IR[7:4]
//   t_state, halted   one-hot ring position, sticky halt flag
//   pc_inc .. alu_en  control lines to PC, MAR, RAM, IR, A, B, ALU, OUT
// ---------------------------------------------------------------------------
module sap_controller
    import sap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [OP_W-1:0]  ir_opcode,
    output logic [NUM_T-1:0] t_state,
    output logic             halted,
    output logic             pc_inc,
    output logic             pc_en,
    output logic             mar_load,
    output logic             mem_enable,
    output logic             ir_load,
    output logic             ir_en,
    output logic             a_load,
    output logic             a_en,
    output logic             b_load,
    output logic             out_load,
    output logic             alu_sub,
    output logic             alu_en
);

    logic  go;
    logic  halt_hit;
    logic  advance;
    ctrl_t ctrl;

    assign go       = !halted && (run || step);
    assign halt_hit = (t_state == T4) && (ir_opcode == OP_HLT);
    // HLT freezes the ring at T4 instead of rotating to T5.
    assign advance  = go && !halt_hit;

    sap_ring_counter u_ring (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .t_state (t_state)
    );

    // Sticky halt: set on the T4 edge of HLT, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  halted <= 1'b0;
        else if (go && halt_hit)  halted <= 1'b1;
    end

    // Control decode. Gating with rst makes the controls drop immediately
    // on an asynchronous reset, not just at the next edge.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (!rst && !halted) begin
            case (t_state)
                T1: begin
                    ctrl.pc_en    = 1'b1;
                    ctrl.mar_load = 1'b1;
                end
                T2: ctrl.pc_inc = 1'b1;
                T3: begin
                    ctrl.mem_enable = 1'b0;
                    ctrl.ir_load    = 1'b1;
                end
                T4: begin
                    if ((ir_opcode == OP_LDA) || is_alu_op(ir_opcode)) begin
                        ctrl.ir_en    = 1'b1;
                        ctrl.mar_load = 1'b1;
                    end else if (ir_opcode == OP_OUT) begin
                        ctrl.a_en     = 1'b1;
                        ctrl.out_load = 1'b1;
                    end
                end
                T5: begin
                    if (ir_opcode == OP_LDA) begin
                        ctrl.mem_enable = 1'b0;
                        ctrl.a_load     = 1'b1;
                    end else if (is_alu_op(ir_opcode)) begin
                        ctrl.mem_enable = 1'b0;
                        ctrl.b_load     = 1'b1;
                    end
                end
                T6: begin
                    if (is_alu_op(ir_opcode)) begin
                        ctrl.alu_en = 1'b1;
                        ctrl.a_load = 1'b1;
                    end
                end
                default: ctrl = CTRL_IDLE;
            endcase
            if ((ir_opcode == OP_SUB) && (t_state inside {T4, T5, T6}))
                ctrl.alu_sub = 1'b1;
        end
    end

    assign pc_inc     = ctrl.pc_inc;
    assign pc_en      = ctrl.pc_en;
    assign mar_load   = ctrl.mar_load;
    assign mem_enable = ctrl.mem_enable;
    assign ir_load    = ctrl.ir_load;
    assign ir_en      = ctrl.ir_en;
    assign a_load     = ctrl.a_load;
    assign a_en       = ctrl.a_en;
    assign b_load     = ctrl.b_load;
    assign out_load   = ctrl.out_load;
    assign alu_sub    = ctrl.alu_sub;
    assign alu_en     = ctrl.alu_en;

    // Only one W-bus driver at a time; PC never counts while it drives.
    bus_exclusive: assert property (@(posedge clk) disable iff (rst)
        $onehot0({pc_en, ir_en, a_en, alu_en, !mem_enable}));
    pc_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(pc_inc && pc_en));

endmodule
